// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 800x600 mode constants, lock states and counter widths
// shared by the sync generator, porch blocks and the receive-side decoder.
package vga_timing_pkg;

  localparam int VGA_DISP_COLS     = 800;
  localparam int VGA_H_FRONT_PORCH = 56;
  localparam int VGA_H_SYNC_WIDTH  = 120;
  localparam int VGA_H_BACK_PORCH  = 64;
  localparam int VGA_TOTAL_COLS    = VGA_DISP_COLS
                                   + VGA_H_FRONT_PORCH
                                   + VGA_H_SYNC_WIDTH
                                   + VGA_H_BACK_PORCH;

  localparam int VGA_DISP_ROWS     = 600;
  localparam int VGA_V_FRONT_PORCH = 37;
  localparam int VGA_V_SYNC_WIDTH  = 6;
  localparam int VGA_V_BACK_PORCH  = 23;
  localparam int VGA_TOTAL_ROWS    = VGA_DISP_ROWS
                                   + VGA_V_FRONT_PORCH
                                   + VGA_V_SYNC_WIDTH
                                   + VGA_V_BACK_PORCH;

  localparam bit VGA_SYNC_ACTIVE   = 1'b1;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int POS_W   = 12;
  localparam int RGB_W   = 8;
  localparam int ERR_W   = 8;

  typedef logic [H_CNT_W-1:0]      h_cnt_t;
  typedef logic [V_CNT_W-1:0]      v_cnt_t;
  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic [RGB_W-1:0]        rgb_t;
  typedef logic [ERR_W-1:0]        err_cnt_t;

  typedef enum logic [1:0] {
    LK_SEARCH = 2'd0,
    LK_VERIFY = 2'd1,
    LK_LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: porched sync + pixel stream as seen at the connector.
// master drives it (transmitter), slave samples it (decoder).
interface vga_sync_decoder_if;
  import vga_timing_pkg::*;

  logic h_sync;
  logic v_sync;
  rgb_t rgb;

  modport master (
    output h_sync,
    output v_sync,
    output rgb
  );

  modport slave (
    input h_sync,
    input v_sync,
    input rgb
  );

endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers one sync input and flags its leading edge
// (registered value at ACTIVE while the previous registered value was not).
module sync_edge_detect #(
  parameter bit ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lead
);

  logic q;
  logic q_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= ~ACTIVE;
      q_prev <= ~ACTIVE;
    end else begin
      q      <= sync_in;
      q_prev <= q;
    end
  end

  assign lead = (q == ACTIVE) && (q_prev != ACTIVE);

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers col/row from a porched VGA stream, checks line
// and frame length against the mode and reports lock; 3-cycle latency.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int DISP_COLS    = VGA_DISP_COLS,
  parameter int DISP_ROWS    = VGA_DISP_ROWS,
  parameter int TOTAL_COLS   = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS   = VGA_TOTAL_ROWS,
  parameter int H_SYNC_WIDTH = VGA_H_SYNC_WIDTH,
  parameter int H_BACK_PORCH = VGA_H_BACK_PORCH,
  parameter int V_SYNC_WIDTH = VGA_V_SYNC_WIDTH,
  parameter int V_BACK_PORCH = VGA_V_BACK_PORCH,
  parameter bit SYNC_ACTIVE  = VGA_SYNC_ACTIVE
) (
  input  logic              clk,
  input  logic              rst,
  vga_sync_decoder_if.slave vid,
  output logic              pixel_valid,
  output h_cnt_t            col,
  output v_cnt_t            row,
  output rgb_t              pixel_rgb,
  output logic              frame_start,
  output logic              locked,
  output logic              timing_error,
  output err_cnt_t          err_count
);

  localparam h_cnt_t H_TOT   = h_cnt_t'(TOTAL_COLS);
  localparam h_cnt_t H_LAST  = h_cnt_t'(TOTAL_COLS - 1);
  localparam v_cnt_t V_TOT   = v_cnt_t'(TOTAL_ROWS);
  localparam v_cnt_t V_LAST  = v_cnt_t'(TOTAL_ROWS - 1);
  localparam pos_t   COL_OFS = pos_t'(H_SYNC_WIDTH + H_BACK_PORCH);
  localparam pos_t   ROW_OFS = pos_t'(V_SYNC_WIDTH + V_BACK_PORCH);
  localparam pos_t   COL_LIM = pos_t'(DISP_COLS);
  localparam pos_t   ROW_LIM = pos_t'(DISP_ROWS);

  logic        h_lead;
  logic        v_lead;
  rgb_t        rgb_q;
  rgb_t        rgb_q2;
  h_cnt_t      h_cnt;
  h_cnt_t      h_cnt_d;
  v_cnt_t      v_cnt;
  v_cnt_t      v_cnt_d;
  lock_state_t state;
  lock_state_t state_d;
  logic        line_err;
  logic        overrun;
  logic        frame_err;
  logic        any_err;
  logic        report;
  logic        count;
  logic        fs_q;
  logic        rep_q;
  logic        inc_q;
  pos_t        col_s;
  pos_t        row_s;
  logic        valid_d;

  sync_edge_detect #(.ACTIVE(SYNC_ACTIVE)) u_hs (
    .clk     (clk),
    .rst     (rst),
    .sync_in (vid.h_sync),
    .lead    (h_lead)
  );

  sync_edge_detect #(.ACTIVE(SYNC_ACTIVE)) u_vs (
    .clk     (clk),
    .rst     (rst),
    .sync_in (vid.v_sync),
    .lead    (v_lead)
  );

  // A v edge coinciding with an h edge closes the frame on that line.
  always_comb begin
    line_err  = h_lead && (h_cnt != H_LAST);
    overrun   = !h_lead && (h_cnt == H_LAST);
    frame_err = 1'b0;
    if (v_lead) begin
      frame_err = h_lead ? (v_cnt != V_LAST)
                         : (v_cnt != V_TOT);
    end
    any_err = line_err || overrun || frame_err;
  end

  always_comb begin
    h_cnt_d = h_cnt;
    if (h_lead) begin
      h_cnt_d = '0;
    end else if (h_cnt != H_TOT) begin
      h_cnt_d = h_cnt + h_cnt_t'(1);
    end
    v_cnt_d = v_cnt;
    if (v_lead) begin
      v_cnt_d = '0;
    end else if (h_lead && (v_cnt != V_TOT)) begin
      v_cnt_d = v_cnt + v_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LK_SEARCH;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    report  = 1'b0;
    count   = 1'b0;
    unique case (state)
      LK_SEARCH: begin
        if (v_lead) state_d = LK_VERIFY;
      end
      LK_VERIFY: begin
        if (any_err) begin
          state_d = LK_SEARCH;
          report  = 1'b1;
        end else if (v_lead) begin
          state_d = LK_LOCKED;
        end
      end
      LK_LOCKED: begin
        if (any_err) begin
          state_d = LK_SEARCH;
          report  = 1'b1;
          count   = 1'b1;
        end
      end
      default: state_d = LK_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q  <= '0;
      rgb_q2 <= '0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      fs_q   <= 1'b0;
      rep_q  <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      rgb_q  <= vid.rgb;
      rgb_q2 <= rgb_q;
      h_cnt  <= h_cnt_d;
      v_cnt  <= v_cnt_d;
      fs_q   <= v_lead;
      rep_q  <= report;
      inc_q  <= count;
    end
  end

  always_comb begin
    col_s   = pos_t'(h_cnt) - COL_OFS;
    row_s   = pos_t'(v_cnt) - ROW_OFS;
    valid_d = (state == LK_LOCKED)
           && !col_s[POS_W-1] && (col_s < COL_LIM)
           && !row_s[POS_W-1] && (row_s < ROW_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid  <= 1'b0;
      col          <= '0;
      row          <= '0;
      pixel_rgb    <= '0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
      err_count    <= '0;
    end else begin
      pixel_valid  <= valid_d;
      col          <= valid_d ? col_s[H_CNT_W-1:0] : '0;
      row          <= valid_d ? row_s[V_CNT_W-1:0] : '0;
      pixel_rgb    <= valid_d ? rgb_q2 : '0;
      frame_start  <= fs_q;
      locked       <= (state == LK_LOCKED);
      timing_error <= rep_q;
      if (inc_q && (err_count != '1)) begin
        err_count <= err_count + err_cnt_t'(1);
      end
    end
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA output path. It samples the porched `h_sync`/`v_sync` and 8-bit `rgb` stream that our display pipeline drives to the connector, recovers column/row position, and checks line and frame timing against the configured mode. It asserts `locked` only while timing is clean. It serves as the loopback checker in the pong FPGA build and as a scoreboard front end in simulation.

## Interface
- `DISP_COLS`, 800: active columns per line
- `DISP_ROWS`, 600: active rows per frame
- `TOTAL_COLS`, 1040: clocks per line, including blanking
- `TOTAL_ROWS`, 666: lines per frame, including blanking
- `H_SYNC_WIDTH`, 120: h_sync pulse width in clocks
- `H_BACK_PORCH`, 64: clocks from the end of h_sync to the first active pixel
- `V_SYNC_WIDTH`, 6: v_sync pulse width in lines
- `V_BACK_PORCH`, 23: lines from the end of v_sync to the first active row
- `SYNC_ACTIVE`, 1: asserted level of both sync inputs

Ports:
- `clk`  in  1  pixel clock; the same clock that drives the transmitter
- `rst`  in  1  synchronous, active-high reset
- `h_sync`  in  1  horizontal sync, with porch
- `v_sync`  in  1  vertical sync, with porch
- `rgb`  in  8  pixel data, RRRGGGBB
- `pixel_valid`  out  1  current output is an active pixel and the decoder is locked
- `col`  out  11  active column, 0..DISP_COLS-1; 0 when not valid
- `row`  out  10  active row, 0..DISP_ROWS-1; 0 when not valid
- `pixel_rgb`  out  8  `rgb` delayed to align with col/row; 0 when not valid
- `frame_start`  out  1  one-cycle pulse when a v_sync leading edge is processed
- `locked`  out  1  timing verified
- `timing_error`  out  1  one-cycle pulse on any line or frame mismatch
- `err_count`  out  8  saturating count of timing errors since reset

## Operation
- Input stage: h_sync, v_sync and rgb are each registered once. A leading edge is detected when the registered value equals SYNC_ACTIVE and the previous registered value does not.
- h_cnt (11 bit):
  - Cleared to 0 on an h_sync leading edge; otherwise increments.
  - Saturates at TOTAL_COLS.
  - When h_cnt reaches TOTAL_COLS, a line overrun is flagged once per line.
- Line length check: at each h_sync leading edge, the old h_cnt+1 must equal TOTAL_COLS. Any other value is a line error.
- v_cnt (10 bit):
  - Increments on each h_sync leading edge.
  - Cleared to 0 on a v_sync leading edge. If both edges occur in the same cycle, v_cnt is 0.
  - Saturates at TOTAL_ROWS.
- Frame check: at a v_sync leading edge, the number of lines counted since the previous v_sync edge must equal TOTAL_ROWS. The first edge after SEARCH is exempt.
- Position: col = h_cnt − (H_SYNC_WIDTH+H_BACK_PORCH) and row = v_cnt − (V_SYNC_WIDTH+V_BACK_PORCH). The pixel is active when both are within range. The subtractions use 12-bit signed width; a negative result means inactive.
- Lock FSM, three states:
  - SEARCH → VERIFY on a v_sync leading edge.
  - VERIFY → LOCKED on the next v_sync leading edge, provided no line or frame error occurred.
  - VERIFY → SEARCH on any error.
  - LOCKED → SEARCH on any error. timing_error pulses and err_count increments, saturating at 255.
  - An error in SEARCH is ignored. An error in VERIFY pulses timing_error but does not increment err_count.
- pixel_valid = LOCKED and active. When pixel_valid is 0, col, row and pixel_rgb are 0.
- Reset: state SEARCH; all counters 0; all outputs 0.
- Reset mid-frame: the lock sequence restarts and requires two new v_sync edges.

## Timing
- Input-to-output latency is 3 cycles. This applies to pixel_valid, col, row, pixel_rgb, frame_start and timing_error relative to the input pins.
- For an h_sync leading edge at input cycle t, the pixel sampled at t+H_SYNC_WIDTH+H_BACK_PORCH appears at the outputs at t+184+3 with col=0.
- `locked` rises 3 cycles after the second clean v_sync edge reaches the input. It falls in the same cycle that timing_error pulses.
- An overrun error fires 3 cycles after the input cycle in which h_cnt reaches TOTAL_COLS.
- Mode arithmetic: TOTAL_COLS = DISP_COLS+56+120+64; TOTAL_ROWS = DISP_ROWS+37+6+23. Front porches are implied by these totals.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 800x600 mode constants, also used by the sync generator and porch blocks;
  - the lock FSM state encoding;
  - the counter widths.
- One sub-module, `sync_edge_detect`: input register plus leading-edge detect. It is instantiated for h_sync and for v_sync.

## Test plan
- Clean 800x600 stimulus from the transmitter, 3 frames → locked rises 3 cycles after the 2nd v_sync edge; frame 3 yields exactly 480000 pixel_valid cycles; err_count=0.
- Pixel data rgb = col[7:0] → every valid output has pixel_rgb == col[7:0]; the first valid cycle of each line has col=0; the last has col=799, row within 0..599.
- While locked, shorten one line to 1039 clocks → one timing_error pulse, locked=0, err_count=1, then re-lock after two clean frames.
- Suppress h_sync for 1100 clocks → overrun timing_error 3 cycles after the input cycle in which h_cnt reaches 1040; locked drops; state returns to SEARCH.
- Frame with 665 lines → frame error at the v_sync edge; err_count increments.
- Assert rst mid-frame while locked → the next cycle has all outputs 0; locked stays 0 until two clean v_sync edges.
